raw_read_sequencer: RTL and testbench

Timing and request controller for the Bayer-to-RGB read path. It sequences pixel reads out of the capture FIFO one line at a time, generates the frame/line qualifiers and X/Y counters consumed by the line buffers and demosaic stage, and holds off each line until the FIFO reports data ready. It sits between the capture FIFO and the RAW-to-RGB conversion block, and is the only source of `READ_Request` in the read path.

---
 rtl/raw_read_pkg.sv | 22 ++
 rtl/raw_read_sequencer_cnt.sv | 29 ++
 rtl/raw_read_sequencer.sv | 174 +++++++++++++++++
 tb/tb_raw_read_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/raw_read_pkg.sv
// Shared types and constants for the RAW read sequencer: FSM states,
// counter widths and default frame timing.
package raw_read_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    localparam int XY_W  = 11;
    localparam int CNT_W = 20;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_BLANK     = 160;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_BLANK     = 45;
    localparam int DEF_PRIME_LINES = 2;

endpackage

// File: rtl/raw_read_sequencer_cnt.sv
// Loadable terminal-count down-counter. It holds at zero until reloaded;
// o_done is high while the count is zero.
module raw_read_cnt #(
    parameter int WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadVal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/raw_read_sequencer.sv
// Line/frame read sequencer for the capture FIFO to RAW-to-RGB path.
// Optional underrun detection is built only when UNDERRUN_DET_EN is defined.
module raw_read_sequencer
    import raw_read_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_BLANK     = DEF_H_BLANK,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_BLANK     = DEF_V_BLANK,
    parameter int PRIME_LINES = DEF_PRIME_LINES
) (
    input  logic            VGA_CLK,
    input  logic            RST,
    input  logic            iENABLE,
    input  logic            iFIFO_RDY,
    input  logic            iFIFO_EMPTY,
    output logic            READ_Request,
    output logic            oVS,
    output logic            oHS,
    output logic [XY_W-1:0] oX_Cont,
    output logic [XY_W-1:0] oY_Cont,
    output logic            oDVAL,
    output logic            oFRAME_DONE,
    output logic            oUNDERRUN
);

    // Counter reload values are one less than the duration: done fires on the last cycle.
    localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HBL_LOAD = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VBL_LOAD = CNT_W'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);
    localparam logic [XY_W-1:0]  Y_LAST   = XY_W'(V_ACTIVE - 1);
    localparam logic [XY_W-1:0]  Y_PRIME  = XY_W'(PRIME_LINES);

    state_t            r_state;
    state_t            w_nextState;
    logic              w_load;
    logic [CNT_W-1:0]  w_loadVal;
    logic [CNT_W-1:0]  w_count;
    logic              w_done;
    logic              w_fdNext;
    logic [XY_W-1:0]   r_x;
    logic [XY_W-1:0]   r_y;
    logic [XY_W-1:0]   w_nextX;
    logic [XY_W-1:0]   w_nextY;
    logic              r_readReq;
    logic              r_vs;
    logic              r_dval;
    logic              r_frameDone;

    raw_read_cnt #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .i_clk    (VGA_CLK),
        .i_rst    (RST),
        .i_load   (w_load),
        .i_loadVal(w_loadVal),
        .o_count  (w_count),
        .o_done   (w_done)
    );

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadVal   = '0;
        w_nextY     = r_y;
        case (r_state)
            IDLE: begin
                if (iENABLE) begin
                    w_nextState = WAIT_LINE;
                    w_nextY     = '0;
                end
            end
            WAIT_LINE: begin
                if (iFIFO_RDY) begin
                    w_nextState = ACTIVE;
                    w_load      = 1'b1;
                    w_loadVal   = ACT_LOAD;
                end
            end
            ACTIVE: begin
                if (w_done) begin
                    w_nextState = HBLANK;
                    w_load      = 1'b1;
                    w_loadVal   = HBL_LOAD;
                end
            end
            HBLANK: begin
                if (w_done) begin
                    if (r_y < Y_LAST) begin
                        w_nextState = WAIT_LINE;
                        w_nextY     = r_y + XY_W'(1);
                    end else begin
                        w_nextState = VBLANK;
                        w_load      = 1'b1;
                        w_loadVal   = VBL_LOAD;
                    end
                end
            end
            VBLANK: begin
                if (w_done) begin
                    w_nextY     = '0;
                    w_nextState = iENABLE ? WAIT_LINE : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead so they come straight from flops.
    always_comb begin
        w_nextX = '0;
        if (w_nextState == ACTIVE) begin
            w_nextX = (r_state == ACTIVE) ? (r_x + XY_W'(1)) : XY_W'(1);
        end
        w_fdNext = (w_nextState == VBLANK) &&
                   (w_load ? (w_loadVal == '0) : (w_count == CNT_W'(1)));
    end

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_x         <= '0;
            r_y         <= '0;
            r_readReq   <= 1'b0;
            r_vs        <= 1'b0;
            r_dval      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_x         <= w_nextX;
            r_y         <= w_nextY;
            r_readReq   <= (w_nextState == ACTIVE);
            r_vs        <= (w_nextState == WAIT_LINE) || (w_nextState == ACTIVE) ||
                           (w_nextState == HBLANK);
            r_dval      <= (w_nextState == ACTIVE) && (w_nextY >= Y_PRIME);
            r_frameDone <= w_fdNext;
        end
    end

`ifdef UNDERRUN_DET_EN
    logic r_underrun;

    always_ff @(posedge VGA_CLK) begin
        if (RST) begin
            r_underrun <= 1'b0;
        end else if (r_readReq && iFIFO_EMPTY) begin
            r_underrun <= 1'b1;
        end
    end

    assign oUNDERRUN = r_underrun;
`else
    logic w_unusedEmpty;
    assign w_unusedEmpty = iFIFO_EMPTY;
    assign oUNDERRUN     = 1'b0;
`endif

    assign READ_Request = r_readReq;
    assign oHS          = r_readReq;
    assign oVS          = r_vs;
    assign oX_Cont      = r_x;
    assign oY_Cont      = r_y;
    assign oDVAL        = r_dval;
    assign oFRAME_DONE  = r_frameDone;

endmodule

// File: tb/tb_raw_read_sequencer.sv
// Scoreboard bench for raw_read_sequencer on a shrunken frame; the expected
// per-cycle outputs come from a line/frame schedule built from the timing rules.
module tb_raw_read_sequencer;

    localparam int H  = 16;
    localparam int B  = 6;
    localparam int V  = 12;
    localparam int VB = 2;
    localparam int P  = 2;

    typedef struct {
        logic        rr;
        logic        vs;
        logic        dval;
        logic        fd;
        logic        un;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    logic        VGA_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iENABLE = 1'b0;
    logic        iFIFO_RDY = 1'b0;
    logic        iFIFO_EMPTY = 1'b0;
    logic        READ_Request;
    logic        oVS;
    logic        oHS;
    logic [10:0] oX_Cont;
    logic [10:0] oY_Cont;
    logic        oDVAL;
    logic        oFRAME_DONE;
    logic        oUNDERRUN;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    bit   expUn = 1'b0;
    bit   finished = 1'b0;

    raw_read_sequencer #(
        .H_ACTIVE   (H),
        .H_BLANK    (B),
        .V_ACTIVE   (V),
        .V_BLANK    (VB),
        .PRIME_LINES(P)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .RST         (RST),
        .iENABLE     (iENABLE),
        .iFIFO_RDY   (iFIFO_RDY),
        .iFIFO_EMPTY (iFIFO_EMPTY),
        .READ_Request(READ_Request),
        .oVS         (oVS),
        .oHS         (oHS),
        .oX_Cont     (oX_Cont),
        .oY_Cont     (oY_Cont),
        .oDVAL       (oDVAL),
        .oFRAME_DONE (oFRAME_DONE),
        .oUNDERRUN   (oUNDERRUN)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic exp_t mk(input logic rr, input logic vs, input logic fd,
                                input int x, input int y);
        exp_t e;
        e.rr   = rr;
        e.vs   = vs;
        e.fd   = fd;
        e.x    = 11'(x);
        e.y    = 11'(y);
        e.dval = rr && (y >= P);
        e.un   = 1'b0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // One displayed cycle: queue what the outputs must show now, then drive
    // the inputs that the next edge will sample.
    task automatic applyStimulus(input logic rst, input logic en, input logic rdy,
                                 input logic empty, input exp_t e);
`ifdef UNDERRUN_DET_EN
        e.un = expUn;
`else
        e.un = 1'b0;
`endif
        expQ.push_back(e);
        RST         = rst;
        iENABLE     = en;
        iFIFO_RDY   = rdy;
        iFIFO_EMPTY = empty;
        @(posedge VGA_CLK);
        #1;
        if (rst) expUn = 1'b0;
        else if (e.rr && empty) expUn = 1'b1;
    endtask

    task automatic idleCycles(input int n, input logic lastEn);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, (i == n - 1) ? lastEn : 1'b0, rb(), rb(), mk(0, 0, 0, 0, 0));
        end
    endtask

    // A whole frame as the outside world sees it: per line a wait of stall+1
    // cycles, H reads numbered 1..H, B blank cycles; then VB*(H+B) blank cycles.
    task automatic runFrame(input int stallLine, input int stallLen,
                            input int emptyLine, input int emptyX,
                            input int rstLine, input int rstX, input logic endEn);
        int s;
        int vbLen;
        logic rstNow;
        for (int l = 0; l < V; l++) begin
            s = (l == stallLine) ? stallLen : int'($urandom_range(0, 2));
            for (int j = 0; j <= s; j++) begin
                applyStimulus(1'b0, rb(), (j == s), rb(), mk(0, 1, 0, 0, l));
            end
            for (int k = 1; k <= H; k++) begin
                rstNow = (l == rstLine) && (k == rstX);
                applyStimulus(rstNow, rb(), rb(), (l == emptyLine) && (k == emptyX),
                              mk(1, 1, 0, k, l));
                if (rstNow) return;
            end
            for (int b = 0; b < B; b++) begin
                applyStimulus(1'b0, rb(), rb(), rb(), mk(0, 1, 0, 0, l));
            end
        end
        vbLen = VB * (H + B);
        for (int v = 0; v < vbLen; v++) begin
            applyStimulus(1'b0, (v == vbLen - 1) ? endEn : rb(), rb(), rb(),
                          mk(0, 0, (v == vbLen - 1), 0, V - 1));
        end
    endtask

    // Monitor: every displayed cycle with a queued expectation is compared.
    always @(negedge VGA_CLK) begin : monitor
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("READ_Request", int'(READ_Request), int'(e.rr));
            checkOutput("oHS", int'(oHS), int'(e.rr));
            checkOutput("oVS", int'(oVS), int'(e.vs));
            checkOutput("oX_Cont", int'(oX_Cont), int'(e.x));
            checkOutput("oY_Cont", int'(oY_Cont), int'(e.y));
            checkOutput("oDVAL", int'(oDVAL), int'(e.dval));
            checkOutput("oFRAME_DONE", int'(oFRAME_DONE), int'(e.fd));
            checkOutput("oUNDERRUN", int'(oUNDERRUN), int'(e.un));
        end
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge VGA_CLK);
        #1;
        idleCycles(4, 1'b1);
        // Stall of 37 before line 5, one empty pulse mid-line 1, keep running.
        runFrame(5, 37, 1, 5, -1, -1, 1'b1);
        // Frame ends with enable low: must fall back to idle.
        runFrame(-1, 0, -1, -1, -1, -1, 1'b0);
        idleCycles(6, 1'b1);
        // Reset in the middle of line 10.
        runFrame(-1, 0, -1, -1, 10, 9, 1'b1);
        idleCycles(3, 1'b1);
        runFrame(-1, 0, 3, 7, -1, -1, 1'b0);
        idleCycles(5, 1'b0);
        @(negedge VGA_CLK);
        #1;
        if (!finished) begin
            finished = 1'b1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #1000000;
        if (!finished) begin
            finished = 1'b1;
            errors++;
            $display("[TB] FAIL watchdog: run did not complete, got timeout expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
